// File: rtl/arb_pkg.sv
// arb_pkg: types and helpers shared by the request arbiter.
//   arb_state_t     - arbiter FSM state encoding (IDLE, GRANT, GAP)
//   onehot_from_idx - index to one-hot conversion, up to MAX_REQ requesters
package arb_pkg;

  localparam int unsigned MAX_REQ = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  // Callers truncate the result to their own requester count.
  function automatic logic [MAX_REQ-1:0] onehot_from_idx(input logic [2:0] idx);
    logic [MAX_REQ-1:0] v;
    v = 8'd0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational priority encoder for the arbiter.
//   req[N]   - request vector
//   mask[N]  - requesters excluded from this pick (bit set = excluded)
//   ptr[IW]  - round-robin start index (always < N)
//   rr_mode  - 0: lowest index wins, 1: first set bit scanning from ptr
//   found    - at least one unmasked request present
//   idx[IW]  - winning index, 0 when found is low
module rr_priority_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  input  logic          rr_mode,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0]  w_eff;
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_pos;

  // Scan from the lowest-priority slot to the highest so the last hit wins.
  always_comb begin
    w_eff = req & ~mask;
    found = 1'b0;
    idx   = '0;
    w_sum = '0;
    w_pos = '0;
    for (int k = N - 1; k >= 0; k--) begin
      // ptr + k is below 2N, so one conditional subtract gives the modulo.
      w_sum = {1'b0, ptr} + (IW + 1)'(k);
      w_pos = rr_mode ? ((w_sum >= (IW + 1)'(N)) ? IW'(w_sum - (IW + 1)'(N))
                                                 : w_sum[IW-1:0])
                      : IW'(k);
      found = found | w_eff[w_pos];
      idx   = w_eff[w_pos] ? w_pos : idx;
    end
  end

endmodule

// File: rtl/req_arbiter.sv
// req_arbiter: shares one downstream resource among N requesters.
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   req[N]         - request vector, bit i = requester i
//   rr_mode        - 0 fixed priority (bit 0 highest), 1 round-robin
//   grant[N]       - registered one-hot grant, zero when nothing granted
//   grant_idx[IW]  - index of the granted requester, 0 when idle
//   busy           - high while a tenure is active
//   timeout_pulse  - one cycle, first gap cycle after a MAX_HOLD preempt
// Every tenure is followed by exactly one zero-grant gap cycle.
module req_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IW      = $clog2(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          rr_mode,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          busy,
  output logic          timeout_pulse
);

  // A 1-bit counter is kept when the timeout is disabled; it never moves.
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

  arb_state_t    r_state;
  logic [IW-1:0] r_winner;
  logic [IW-1:0] r_ptr;
  logic [HW-1:0] r_hold_cnt;
  logic [N-1:0]  r_grant;
  logic [IW-1:0] r_grant_idx;
  logic          r_busy;
  logic          r_timeout_pulse;

  arb_state_t    w_state_nxt;
  logic [IW-1:0] w_winner_nxt;
  logic [IW-1:0] w_ptr_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic          w_pulse_nxt;
  logic [N-1:0]  w_mask;
  logic          w_found;
  logic [IW-1:0] w_pick_idx;
  logic [IW-1:0] w_ptr_after;

  // In GAP the previous winner sits out one arbitration round.
  assign w_mask      = (r_state == ST_GAP) ? N'(onehot_from_idx(3'(r_winner))) : '0;
  assign w_ptr_after = (r_winner == LAST_IDX) ? '0 : r_winner + IW'(1);

  rr_priority_pick #(.N(N)) u_pick (
    .req     (req),
    .mask    (w_mask),
    .ptr     (r_ptr),
    .rr_mode (rr_mode),
    .found   (w_found),
    .idx     (w_pick_idx)
  );

  // Next-state logic for the IDLE/GRANT/GAP arbiter FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_winner_nxt = r_winner;
    w_ptr_nxt    = r_ptr;
    w_hold_nxt   = r_hold_cnt;
    w_pulse_nxt  = 1'b0;
    case (r_state)
      ST_IDLE, ST_GAP: begin
        if (w_found) begin
          w_state_nxt  = ST_GRANT;
          w_winner_nxt = w_pick_idx;
          w_hold_nxt   = '0;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!req[r_winner]) begin
          w_state_nxt = ST_GAP;
          w_ptr_nxt   = w_ptr_after;
        end else if ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST)) begin
          w_state_nxt = ST_GAP;
          w_ptr_nxt   = w_ptr_after;
          w_pulse_nxt = 1'b1;
        end else begin
          // Counter only advances when it can reach HOLD_LAST, so it never wraps.
          w_hold_nxt  = (MAX_HOLD != 0) ? r_hold_cnt + HW'(1) : r_hold_cnt;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; outputs derive from next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_winner        <= '0;
      r_ptr           <= '0;
      r_hold_cnt      <= '0;
      r_grant         <= '0;
      r_grant_idx     <= '0;
      r_busy          <= 1'b0;
      r_timeout_pulse <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_winner        <= w_winner_nxt;
      r_ptr           <= w_ptr_nxt;
      r_hold_cnt      <= w_hold_nxt;
      r_grant         <= (w_state_nxt == ST_GRANT) ? N'(onehot_from_idx(3'(w_winner_nxt))) : '0;
      r_grant_idx     <= (w_state_nxt == ST_GRANT) ? w_winner_nxt : '0;
      r_busy          <= (w_state_nxt == ST_GRANT);
      r_timeout_pulse <= w_pulse_nxt;
    end
  end

  assign grant         = r_grant;
  assign grant_idx     = r_grant_idx;
  assign busy          = r_busy;
  assign timeout_pulse = r_timeout_pulse;

endmodule
